// File: rtl/bp_cfg_mc_if.sv
// rtl/bp_cfg_mc_if.sv - config link command/response bundle for bp_cfg_mc
interface bp_cfg_mc_if #(
  parameter int cfg_addr_width_p = 16,
  parameter int cfg_data_width_p = 64
);
  logic                        cmd_v_i;
  logic                        cmd_w_i;
  logic [cfg_addr_width_p-1:0] cmd_addr_i;
  logic [cfg_data_width_p-1:0] cmd_data_i;
  logic                        cmd_ready_o;
  logic                        resp_v_o;
  logic                        resp_w_o;
  logic                        resp_err_o;
  logic [cfg_data_width_p-1:0] resp_data_o;
  logic                        resp_ready_i;

  modport slave (
    input  cmd_v_i, cmd_w_i, cmd_addr_i, cmd_data_i, resp_ready_i,
    output cmd_ready_o, resp_v_o, resp_w_o, resp_err_o, resp_data_o
  );

  modport master (
    output cmd_v_i, cmd_w_i, cmd_addr_i, cmd_data_i, resp_ready_i,
    input  cmd_ready_o, resp_v_o, resp_w_o, resp_err_o, resp_data_o
  );
endinterface

// File: rtl/bp_cfg_mc.sv
// rtl/bp_cfg_mc.sv - multi-core config endpoint routing commands to per-core config buses
// Optional broadcast select (sel = 4'hF) enabled by defining BP_CFG_MC_BCAST_EN.
module bp_cfg_mc #(
  parameter int num_core_p       = 4,
  parameter int cfg_addr_width_p = 16,
  parameter int cfg_data_width_p = 64,
  parameter int read_latency_p   = 1,
  parameter int freeze_offset_p  = 'h001
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  bp_cfg_mc_if.slave                             link,
  output logic [num_core_p-1:0]                  cfg_v_o,
  output logic                                   cfg_w_o,
  output logic [cfg_addr_width_p-5:0]            cfg_addr_o,
  output logic [cfg_data_width_p-1:0]            cfg_data_o,
  input  logic [num_core_p*cfg_data_width_p-1:0] cfg_rdata_i,
  output logic [num_core_p-1:0]                  freeze_o
);
  localparam int off_w_lp = cfg_addr_width_p - 4;
  localparam int dw_lp    = cfg_data_width_p;
  localparam logic [4:0]          num_core_lp   = 5'(num_core_p);
  localparam logic [2:0]          latency_lp    = 3'(read_latency_p);
  localparam logic [off_w_lp-1:0] freeze_off_lp = off_w_lp'(freeze_offset_p);

  typedef enum logic [1:0] {READY, ISSUE, WAIT, RESP} state_e;

  state_e                r_state, w_state_next;
  logic                  r_w;
  logic [3:0]            r_sel;
  logic [off_w_lp-1:0]   r_off;
  logic [dw_lp-1:0]      r_data;
  logic [2:0]            r_cnt;
  logic                  r_resp_w, r_resp_err;
  logic [dw_lp-1:0]      r_resp_data;
  logic [num_core_p-1:0] r_freeze;

  logic                  w_accept, w_bcast, w_err, w_local, w_core, w_frz_bit, w_capture;
  logic [num_core_p-1:0] w_onehot, w_freeze_next;
  logic [dw_lp-1:0]      w_rdata;

  assign w_accept  = link.cmd_v_i & (r_state == READY);
  assign w_capture = (r_state == WAIT) && (r_cnt <= 3'd1);

  // Decode works off the latched command so the core-side fields stay registered.
  always_comb begin
`ifdef BP_CFG_MC_BCAST_EN
    w_bcast = (r_sel == 4'hF);
    w_err   = w_bcast ? ~r_w : ({1'b0, r_sel} >= num_core_lp);
`else
    w_bcast = 1'b0;
    w_err   = ({1'b0, r_sel} >= num_core_lp);
`endif
    w_local       = ~w_err & (r_off == freeze_off_lp);
    w_core        = ~w_err & ~w_local;
    w_onehot      = '0;
    w_frz_bit     = 1'b0;
    w_rdata       = '0;
    w_freeze_next = r_freeze;
    for (int i = 0; i < num_core_p; i++) begin
      w_onehot[i] = (r_sel == 4'(i));
      if (r_sel == 4'(i)) begin
        w_frz_bit = r_freeze[i];
        w_rdata   = cfg_rdata_i[i*dw_lp +: dw_lp];
      end
    end
    if (w_local & r_w) begin
      if (w_bcast) w_freeze_next = {num_core_p{r_data[0]}};
      else         w_freeze_next = (r_freeze & ~w_onehot) | (w_onehot & {num_core_p{r_data[0]}});
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      READY: if (link.cmd_v_i) w_state_next = ISSUE;
      ISSUE: w_state_next = (w_core & ~r_w) ? WAIT : RESP;
      WAIT:  if (w_capture) w_state_next = RESP;
      RESP:  if (link.resp_ready_i) w_state_next = READY;
      default: w_state_next = READY;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_state <= READY;
    else         r_state <= w_state_next;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_w         <= 1'b0;
      r_sel       <= '0;
      r_off       <= '0;
      r_data      <= '0;
      r_cnt       <= '0;
      r_resp_w    <= 1'b0;
      r_resp_err  <= 1'b0;
      r_resp_data <= '0;
      r_freeze    <= '1;
    end else begin
      if (w_accept) begin
        r_w    <= link.cmd_w_i;
        r_sel  <= link.cmd_addr_i[cfg_addr_width_p-1 -: 4];
        r_off  <= link.cmd_addr_i[off_w_lp-1:0];
        r_data <= link.cmd_data_i;
      end
      if (r_state == ISSUE) begin
        r_resp_w    <= r_w;
        r_resp_err  <= w_err;
        r_resp_data <= (w_local & ~r_w) ? {{(dw_lp-1){1'b0}}, w_frz_bit} : '0;
        r_freeze    <= w_freeze_next;
        if (w_core & ~r_w) r_cnt <= latency_lp;
      end
      if (r_state == WAIT) begin
        r_cnt <= r_cnt - 3'd1;
        if (w_capture) r_resp_data <= w_rdata;
      end
    end
  end

  assign cfg_v_o    = ((r_state == ISSUE) && w_core) ? (w_bcast ? '1 : w_onehot) : '0;
  assign cfg_w_o    = r_w;
  assign cfg_addr_o = r_off;
  assign cfg_data_o = r_data;
  assign freeze_o   = r_freeze;

  assign link.cmd_ready_o = (r_state == READY);
  assign link.resp_v_o    = (r_state == RESP);
  assign link.resp_w_o    = r_resp_w;
  assign link.resp_err_o  = r_resp_err;
  assign link.resp_data_o = r_resp_data;
endmodule

// File: tb/tb_bp_cfg_mc.sv
// tb/tb_bp_cfg_mc.sv - directed vector bench for bp_cfg_mc (4 cores, read latency 3)
module tb_bp_cfg_mc;
  localparam int N = 4;
  localparam int L = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] cfg_v;
  logic         cfg_w;
  logic [11:0]  cfg_addr;
  logic [63:0]  cfg_data;
  logic [N*64-1:0] cfg_rdata = '0;
  logic [N-1:0] freeze;
  logic [N-1:0] hist [0:L];

  int n_cmp = 0;
  int n_bad = 0;

  bp_cfg_mc_if #(.cfg_addr_width_p(16), .cfg_data_width_p(64)) lnk ();

  bp_cfg_mc #(
    .num_core_p(N), .cfg_addr_width_p(16), .cfg_data_width_p(64),
    .read_latency_p(L), .freeze_offset_p('h001)
  ) dut (
    .clk_i(clk), .reset_i(rst), .link(lnk),
    .cfg_v_o(cfg_v), .cfg_w_o(cfg_w), .cfg_addr_o(cfg_addr), .cfg_data_o(cfg_data),
    .cfg_rdata_i(cfg_rdata), .freeze_o(freeze)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] core_val(input int i);
    return (i == 1) ? 64'hDEAD_BEEF : (64'hC0DE_0000_0000_0000 | 64'(i));
  endfunction

  // Core model: read data is valid only L cycles after the strobe, garbage otherwise.
  initial for (int k = 0; k <= L; k++) hist[k] = '0;
  always @(negedge clk) begin
    for (int k = L; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = cfg_v;
    for (int i = 0; i < N; i++)
      cfg_rdata[i*64 +: 64] = hist[L][i] ? core_val(i) : 64'hBAD0_BAD0_BAD0_BAD0;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  int          g_resp_cyc, g_cfgv_cyc, g_cfgv_cnt;
  logic [3:0]  g_cfgv_val;
  logic        g_err, g_w, g_cfgw;
  logic [63:0] g_data, g_cfgd;
  logic [11:0] g_addr;

  // Starts at a negedge; returns at the negedge of the response cycle (hold=1)
  // or at the negedge after the response handshake (hold=0).
  task automatic run_cmd(input logic w, input logic [15:0] a, input logic [63:0] d, input bit hold);
    int waits = 0;
    g_resp_cyc = -1; g_cfgv_cyc = -1; g_cfgv_cnt = 0; g_cfgv_val = '0;
    g_err = 1'bx; g_w = 1'bx; g_data = 'x;
    while (!lnk.cmd_ready_o && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    chk("cmd_ready_wait", 64'(lnk.cmd_ready_o), 64'd1);
    lnk.cmd_v_i = 1'b1; lnk.cmd_w_i = w; lnk.cmd_addr_i = a; lnk.cmd_data_i = d;
    @(posedge clk); #1;
    lnk.cmd_v_i = 1'b0;
    for (int cyc = 1; cyc < 40; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        g_addr = cfg_addr; g_cfgw = cfg_w; g_cfgd = cfg_data;
      end
      if (cfg_v != '0) begin
        if (g_cfgv_cyc < 0) begin
          g_cfgv_cyc = cyc; g_cfgv_val = cfg_v;
        end
        g_cfgv_cnt++;
      end
      if (lnk.resp_v_o) begin
        g_resp_cyc = cyc; g_err = lnk.resp_err_o; g_w = lnk.resp_w_o; g_data = lnk.resp_data_o;
        break;
      end
    end
    if (!hold) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic        w;
    logic [15:0] addr;
    logic [63:0] data;
    logic        err;
    logic [63:0] rdata;
    logic [3:0]  cfgv;
    int          resp_cyc;
    logic [3:0]  frz;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic w, input logic [15:0] a, input logic [63:0] d, input logic e,
                     input logic [63:0] rd, input logic [3:0] cv, input int rc, input logic [3:0] fz);
    vec_t v;
    v.w = w; v.addr = a; v.data = d; v.err = e; v.rdata = rd; v.cfgv = cv; v.resp_cyc = rc; v.frz = fz;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int bad_cyc;
    int seen_v;
    int seen_cfg;
    //   w     addr      data           err   rdata                    cfgv     cyc   freeze
    add(1'b1, 16'h2001, 64'h0,         1'b0, 64'h0,                   4'b0000, 2,    4'b1011);
    add(1'b0, 16'h2001, 64'h0,         1'b0, 64'h0,                   4'b0000, 2,    4'b1011);
    add(1'b0, 16'h0001, 64'h0,         1'b0, 64'h1,                   4'b0000, 2,    4'b1011);
    add(1'b0, 16'h1040, 64'h0,         1'b0, 64'hDEAD_BEEF,           4'b0010, 2+L,  4'b1011);
    add(1'b1, 16'h3010, 64'h55,        1'b0, 64'h0,                   4'b1000, 2,    4'b1011);
    add(1'b0, 16'h3123, 64'h0,         1'b0, 64'hC0DE_0000_0000_0003, 4'b1000, 2+L,  4'b1011);
    add(1'b1, 16'h7010, 64'h77,        1'b1, 64'h0,                   4'b0000, 2,    4'b1011);
    add(1'b0, 16'h4001, 64'h0,         1'b1, 64'h0,                   4'b0000, 2,    4'b1011);
    add(1'b1, 16'h2001, 64'h3,         1'b0, 64'h0,                   4'b0000, 2,    4'b1111);
    add(1'b1, 16'h0001, 64'h0,         1'b0, 64'h0,                   4'b0000, 2,    4'b1110);
    add(1'b0, 16'h0001, 64'h0,         1'b0, 64'h0,                   4'b0000, 2,    4'b1110);
`ifdef BP_CFG_MC_BCAST_EN
    add(1'b1, 16'hF010, 64'h5,         1'b0, 64'h0,                   4'b1111, 2,    4'b1110);
    add(1'b1, 16'hF001, 64'h0,         1'b0, 64'h0,                   4'b0000, 2,    4'b0000);
    add(1'b0, 16'hF010, 64'h0,         1'b1, 64'h0,                   4'b0000, 2,    4'b0000);
    add(1'b1, 16'hF001, 64'h1,         1'b0, 64'h0,                   4'b0000, 2,    4'b1111);
`else
    add(1'b1, 16'hF010, 64'h5,         1'b1, 64'h0,                   4'b0000, 2,    4'b1110);
`endif

    lnk.cmd_v_i = 1'b0; lnk.cmd_w_i = 1'b0; lnk.cmd_addr_i = '0; lnk.cmd_data_i = '0;
    lnk.resp_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_freeze", 64'(freeze), 64'hF);
    chk("rst_cmd_ready", 64'(lnk.cmd_ready_o), 64'd1);
    chk("rst_resp_v", 64'(lnk.resp_v_o), 64'd0);
    chk("rst_resp_data", lnk.resp_data_o, 64'd0);
    chk("rst_cfg_v", 64'(cfg_v), 64'd0);
    chk("rst_cfg_addr", 64'(cfg_addr), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[k]) begin
      run_cmd(vecs[k].w, vecs[k].addr, vecs[k].data, 1'b0);
      chk($sformatf("v%0d_resp_cyc", k), 64'(g_resp_cyc), 64'(vecs[k].resp_cyc));
      chk($sformatf("v%0d_err", k), 64'(g_err), 64'(vecs[k].err));
      chk($sformatf("v%0d_resp_w", k), 64'(g_w), 64'(vecs[k].w));
      chk($sformatf("v%0d_data", k), g_data, vecs[k].rdata);
      chk($sformatf("v%0d_cfg_v", k), 64'(g_cfgv_val), 64'(vecs[k].cfgv));
      chk($sformatf("v%0d_cfg_v_cyc", k), 64'(g_cfgv_cyc), (vecs[k].cfgv != 0) ? 64'd1 : -64'sd1);
      chk($sformatf("v%0d_cfg_v_cnt", k), 64'(g_cfgv_cnt), (vecs[k].cfgv != 0) ? 64'd1 : 64'd0);
      chk($sformatf("v%0d_cfg_addr", k), 64'(g_addr), 64'(vecs[k].addr[11:0]));
      chk($sformatf("v%0d_cfg_w", k), 64'(g_cfgw), 64'(vecs[k].w));
      chk($sformatf("v%0d_cfg_data", k), g_cfgd, vecs[k].data);
      chk($sformatf("v%0d_freeze", k), 64'(freeze), 64'(vecs[k].frz));
    end

    // Backpressure: response must hold steady and no new command accepted.
    lnk.resp_ready_i = 1'b0;
    run_cmd(1'b0, 16'h1040, 64'h0, 1'b1);
    chk("bp_resp_cyc", 64'(g_resp_cyc), 64'(2+L));
    chk("bp_data", g_data, 64'hDEAD_BEEF);
    bad_cyc = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!lnk.resp_v_o || lnk.resp_data_o !== 64'hDEAD_BEEF || lnk.resp_err_o || lnk.resp_w_o
          || lnk.cmd_ready_o) bad_cyc++;
    end
    chk("bp_stable_cycles_bad", 64'(bad_cyc), 64'd0);
    lnk.resp_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_after_resp_v", 64'(lnk.resp_v_o), 64'd0);
    chk("bp_after_cmd_ready", 64'(lnk.cmd_ready_o), 64'd1);

    // Reset in the middle of WAIT aborts the read.
    lnk.cmd_v_i = 1'b1; lnk.cmd_w_i = 1'b0; lnk.cmd_addr_i = 16'h1040; lnk.cmd_data_i = '0;
    @(posedge clk); #1;
    lnk.cmd_v_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_wait_cmd_ready", 64'(lnk.cmd_ready_o), 64'd0);
    rst = 1'b1;
    #1;
    chk("rst_async_cmd_ready", 64'(lnk.cmd_ready_o), 64'd1);
    chk("rst_async_resp_v", 64'(lnk.resp_v_o), 64'd0);
    chk("rst_async_freeze", 64'(freeze), 64'hF);
    @(negedge clk);
    rst = 1'b0;
    seen_v = 0; seen_cfg = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (lnk.resp_v_o) seen_v++;
      if (cfg_v != '0) seen_cfg++;
    end
    chk("abort_resp_v_seen", 64'(seen_v), 64'd0);
    chk("abort_cfg_v_seen", 64'(seen_cfg), 64'd0);

    run_cmd(1'b0, 16'h1040, 64'h0, 1'b0);
    chk("recover_resp_cyc", 64'(g_resp_cyc), 64'(2+L));
    chk("recover_data", g_data, 64'hDEAD_BEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bp_cfg_mc.md
# bp_cfg_mc

Multi-core configuration endpoint that replaces the single-core config block on tiles hosting several cores behind one config link. It accepts uncached read/write commands and routes them to one of `num_core_p` per-core config buses by address. It owns the per-core freeze bits locally and returns one response per command. Read latency of the core-side buses is a parameter, and core-side reads are pipeline-aligned so that no response FIFO is needed.

## Interface
- `num_core_p`, 4: attached cores; legal range 1..15.
- `cfg_addr_width_p`, 16: command address width. Bits [top:top-3] are the core select (`sel`); the remaining bits are the offset.
- `cfg_data_width_p`, 64: data width.
- `read_latency_p`, 1: cycles from `cfg_v_o` to valid `cfg_rdata_i`; legal range 1..7.
- `freeze_offset_p`, 'h001: offset of the local freeze register.

Ports:
- `clk_i` in 1: clock.
- `reset_i` in 1: asynchronous, active-high reset.
- `cmd_v_i` in 1: command valid.
- `cmd_w_i` in 1: 1 = write, 0 = read.
- `cmd_addr_i` in `cfg_addr_width_p`: command address.
- `cmd_data_i` in `cfg_data_width_p`: write data.
- `cmd_ready_o` out 1: ready; a command is accepted when `cmd_v_i & cmd_ready_o`.
- `resp_v_o` out 1: response valid.
- `resp_w_o` out 1: echoes `cmd_w_i`.
- `resp_err_o` out 1: bad core select.
- `resp_data_o` out `cfg_data_width_p`: read data; 0 for writes and errors.
- `resp_ready_i` in 1: consumer ready.
- `cfg_v_o` out `num_core_p`: one-hot per-core strobe, or all-ones for a broadcast.
- `cfg_w_o` out 1: write/read qualifier.
- `cfg_addr_o` out `cfg_addr_width_p-4`: offset.
- `cfg_data_o` out `cfg_data_width_p`: write data.
- `cfg_rdata_i` in `num_core_p*cfg_data_width_p`: per-core read data.
- `freeze_o` out `num_core_p`: per-core freeze.

## Operation
- FSM states: READY, ISSUE, WAIT, RESP. Reset state is READY.
- READY: `cmd_ready_o`=1. On accept, latch w/addr/data and go to ISSUE. `cmd_ready_o` is 0 in every other state, so requests are serialized.
- ISSUE, decoded from the latched command:
  - `sel >= num_core_p` and not broadcast: error; go to RESP with err=1, data=0. No `cfg_v_o`.
  - Offset == `freeze_offset_p`: handled locally. A write sets `freeze_o[sel]` from data bit 0. A read returns the zero-extended freeze bit. Go to RESP. No `cfg_v_o`.
  - Otherwise: drive `cfg_v_o[sel]` for exactly one cycle.
    - Write: go to RESP.
    - Read: load the latency counter with `read_latency_p` and go to WAIT.
- WAIT: decrement the counter each cycle. At 0, capture `cfg_rdata_i` slice `sel` into the response register and go to RESP.
- RESP: `resp_v_o`=1 with stable fields. Leave to READY on `resp_v_o & resp_ready_i`. With backpressure, hold indefinitely.
- Broadcast (see Configuration): `sel`=4'hF.
  - Write: all `cfg_v_o` bits are 1 for one cycle. If the offset is the freeze offset, all `freeze_o` bits are written instead.
  - Read: error response.

## Timing
- Reset values: `freeze_o`=all 1s, `cmd_ready_o`=1; `resp_v_o`, `resp_err_o`, `resp_w_o`, `resp_data_o`, `cfg_v_o`, `cfg_w_o`, `cfg_addr_o`, `cfg_data_o`=0; counter=0.
- Asserting `reset_i` in any state aborts the command immediately: the response is dropped and no further `cfg_v_o` is issued.
- Cycle numbering, with accept at cycle 0:
  - `cfg_v_o` at cycle 1.
  - Writes, local accesses and errors: `resp_v_o` at cycle 2.
  - Core reads: data sampled at cycle 1+`read_latency_p`; `resp_v_o` at cycle 2+`read_latency_p`.
- Back-to-back: the next command is accepted in the cycle after the response handshake, so the minimum period for writes is 3 cycles.
- `cfg_addr_o`, `cfg_data_o` and `cfg_w_o` are registered. They are valid in the ISSUE cycle and hold until the next accept.
- `cfg_rdata_i` is ignored outside the capture cycle.
- `freeze_o` updates on the clock edge that ends ISSUE.

## Configuration
- `BP_CFG_MC_BCAST_EN`
  - Defined: `sel`=4'hF is broadcast, with the behaviour given under Operation.
  - Undefined: 4'hF is an ordinary select value, so it is an error whenever `num_core_p` <= 15, which covers the whole legal range. No broadcast logic is generated.

## Test plan
- Reset: `freeze_o`=4'b1111, `cmd_ready_o`=1, `resp_v_o`=0.
- Write `addr`=16'h2001, data=0: `freeze_o`=4'b1011 at cycle 2, no `cfg_v_o`. Read back returns 64'h0.
- Read `addr`=16'h1040 with `read_latency_p`=3 and core 1 returning 64'hDEAD_BEEF:
  - `cfg_v_o`=4'b0010 at cycle 1.
  - `resp_v_o`=1 at cycle 5 with data 64'hDEAD_BEEF.
- Write `addr`=16'h7010 with `num_core_p`=4:
  - `resp_err_o`=1, data=0, no `cfg_v_o`.
- `BP_CFG_MC_BCAST_EN` defined:
  - Write 16'hF010: `cfg_v_o`=4'b1111 for one cycle.
  - Write 16'hF001 with data 0: `freeze_o`=0.
  - Read 16'hF010: err=1.
- `resp_ready_i` held 0 for 10 cycles: response fields stable and `cmd_ready_o`=0. Assert `reset_i` mid-WAIT: `resp_v_o` never rises, and `cmd_ready_o`=1 immediately.
